// File: rtl/nibble_serial_addsub_if.sv
// Operand request / result response bundle for the nibble-serial add/sub unit.
// master = operand producer and result consumer, slave = the sequencer.
interface nibble_serial_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_z;
    logic             flag_n;
    logic             flag_v;
    logic             flag_c;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, flag_z, flag_n, flag_v, flag_c
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, flag_z, flag_n, flag_v, flag_c
    );
endinterface

// File: rtl/nibble_serial_addsub.sv
// WIDTH-bit add/subtract done one nibble per cycle (LSB first) through a single
// 4-bit carry-lookahead slice; assembles result and Z/N/V/C flags.

module nsa_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       sub,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] bx, g, p;
    logic [4:0] c;

    // sub pin inverts B and forces carry-in; only usable on a lone nibble
    assign bx   = sub ? ~b : b;
    assign g    = a & bx;
    assign p    = a ^ bx;
    assign c[0] = sub | cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
    assign sum  = p ^ c[3:0];
    assign cout = c[4];
endmodule

module nibble_serial_addsub #(
    parameter int WIDTH = 16
) (
    input logic                 clk,
    input logic                 rst,
    nibble_serial_addsub_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int NCW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_nx;
    logic             sub_q, carry_q;
    logic [NCW-1:0]   nib_cnt;
    logic [NCW+1:0]   bit_ofs;
    logic             in_ready_q, out_valid_q;
    logic             z_q, n_q, v_q, c_q;
    logic             last_nib;

    logic [3:0] s_a, s_b, s_sum;
    logic       s_cin, s_cout;

    assign bit_ofs  = {nib_cnt, 2'b00};
    assign last_nib = (nib_cnt == NCW'(NIB - 1));

    always_comb begin
        s_a    = a_q[bit_ofs +: 4];
        s_b    = b_q[bit_ofs +: 4];
        s_cin  = (nib_cnt == '0) ? sub_q : carry_q;
        res_nx = res_q;
        res_nx[bit_ofs +: 4] = s_sum;
    end

    // B is pre-inverted at accept; the slice sub pin stays low
    nsa_cla4 u_slice (
        .a    (s_a),
        .b    (s_b),
        .cin  (s_cin),
        .sub  (1'b0),
        .sum  (s_sum),
        .cout (s_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            nib_cnt     <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            res_q       <= '0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            v_q         <= 1'b0;
            c_q         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_q        <= bus.a;
                        b_q        <= bus.sub ? ~bus.b : bus.b;
                        sub_q      <= bus.sub;
                        nib_cnt    <= '0;
                        in_ready_q <= 1'b0;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    res_q   <= res_nx;
                    carry_q <= s_cout;
                    nib_cnt <= nib_cnt + NCW'(1);
                    if (last_nib) begin
                        z_q         <= ~|res_nx;
                        n_q         <= res_nx[WIDTH-1];
                        c_q         <= s_cout;
                        v_q         <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                       (res_nx[WIDTH-1] != a_q[WIDTH-1]);
                        out_valid_q <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = res_q;
    assign bus.flag_z    = z_q;
    assign bus.flag_n    = n_q;
    assign bus.flag_v    = v_q;
    assign bus.flag_c    = c_q;
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed-vector bench for nibble_serial_addsub at WIDTH=16; expected values
// are hand-computed constants.
module tb_nibble_serial_addsub;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    nibble_serial_addsub_if #(.WIDTH(16)) bus ();

    nibble_serial_addsub #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] flags();
        return {bus.flag_z, bus.flag_n, bus.flag_v, bus.flag_c};
    endfunction

    // Issue one op with out_ready high; check latency, result, flags, return to idle.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic [15:0] er, input logic [3:0] ef);
        int n;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.sub = sub; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a = 16'hdead; bus.b = 16'hbeef; bus.sub = ~sub;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".latency"}, 32'(n), 32'd4);
        chk({tag, ".result"}, 32'(bus.result), 32'(er));
        chk({tag, ".flags"}, 32'(flags()), 32'(ef));
        @(negedge clk);
        chk({tag, ".idle"}, {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
        chk({tag, ".hold"}, 32'(bus.result), 32'(er));
    endtask

    initial begin
        int n;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.ready_valid", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
        chk("rst.result", 32'(bus.result), 32'd0);
        chk("rst.flags", 32'(flags()), 32'd0);
        rst = 1'b0;

        // flags order {Z,N,V,C}
        do_op("basic",   16'h1234, 16'h0001, 1'b0, 16'h1235, 4'b0000);
        do_op("ripple",  16'h0FFF, 16'h0001, 1'b0, 16'h1000, 4'b0000);
        do_op("wrap",    16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b1001);
        do_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 4'b0100);
        do_op("sub_pos", 16'h0007, 16'h0005, 1'b1, 16'h0002, 4'b0001);
        do_op("sub_eq",  16'h1234, 16'h1234, 1'b1, 16'h0000, 4'b1001);
        do_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b0110);
        do_op("ovf_sub", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 4'b0011);
        do_op("ovf_min", 16'h8000, 16'h8000, 1'b0, 16'h0000, 4'b1011);

        // backpressure: hold in DONE, new requests must be ignored
        @(negedge clk);
        bus.a = 16'h1111; bus.b = 16'h2222; bus.sub = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp.latency", 32'(n), 32'd4);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.a = 16'h0F0F; bus.b = 16'h00F0; bus.sub = 1'b1;
            @(negedge clk);
            chk("bp.result", 32'(bus.result), 32'h3333);
            chk("bp.flags", 32'(flags()), 32'd0);
            chk("bp.ready_valid", {30'd0, bus.in_ready, bus.out_valid}, 32'b01);
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp.release", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
        chk("bp.hold", 32'(bus.result), 32'h3333);

        // reset while the slice is on nibble 2
        @(negedge clk);
        bus.a = 16'h1234; bus.b = 16'h0001; bus.sub = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort.ready_valid", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
        chk("abort.result", 32'(bus.result), 32'd0);
        chk("abort.flags", 32'(flags()), 32'd0);
        rst = 1'b0;
        do_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
